// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and entry-register bus
// Purpose: bundles the keypad matrix wiring and the digit-entry outputs.
// Ports:   col_n     - column sense lines, active-low
//          clear     - synchronous clear of the entry register
//          row_n     - row drive, one bit low
//          key_code  - last accepted hex digit
//          key_valid - one-clk pulse per accepted key
//          data      - 32-bit entry register, newest digit in [3:0]
//          state     - debug FSM state
// Modports: master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
   logic [3:0]  col_n;
   logic        clear;
   logic [3:0]  row_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [31:0] data;
   logic [1:0]  state;

   modport master (
      input  col_n, clear,
      output row_n, key_code, key_valid, data, state
   );

   modport slave (
      output col_n, clear,
      input  row_n, key_code, key_valid, data, state
   );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - scanned 4x4 hex keypad with debounce and entry register
// Purpose: drives one row low at a time, debounces presses and releases on the
//          scan tick, and shifts each accepted digit into a 32-bit register.
// Ports:   clk   - system clock
//          rst_n - asynchronous active-low reset
//          kp    - keypad_scanner_if.master (col_n, clear in;
//                  row_n, key_code, key_valid, data, state out)
module keypad_scanner #(
   parameter int SCAN_DIV_W     = 15,
   parameter int DEBOUNCE_TICKS = 4
) (
   input logic              clk,
   input logic              rst_n,
   keypad_scanner_if.master kp
);

   localparam int CNT_W = (DEBOUNCE_TICKS < 2) ? 1 : $clog2(DEBOUNCE_TICKS + 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_RELEASE  = 2'd2
   } state_t;

   logic [3:0]            sync1, cs;
   logic [SCAN_DIV_W-1:0] div;
   state_t                st, st_nxt;
   logic [1:0]            rowi, rowi_nxt;
   logic [3:0]            row_n_q;
   logic [1:0]            cand, cand_nxt;
   logic [CNT_W-1:0]      deb_cnt, cnt_nxt, cnt_inc;
   logic [3:0]            code_q, code_nxt;
   logic                  valid_q, valid_nxt;
   logic [31:0]           data_q, data_nxt;
   logic                  tick, any_low, accept;
   logic [1:0]            low_col;
   logic [3:0]            digit;

   // Lowest-index pressed column wins when several keys share the row.
   function automatic logic [1:0] find_low(input logic [3:0] c);
      if (!c[0])      return 2'd0;
      else if (!c[1]) return 2'd1;
      else if (!c[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
         4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
         4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
         4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
      endcase
   endfunction

   assign tick    = &div;
   assign any_low = ~&cs;
   assign low_col = find_low(cs);
   assign cnt_inc = deb_cnt + 1'b1;
   // In DEBOUNCE an accept requires low_col == cand, so low_col is always the
   // column being accepted.
   assign digit   = key_map(rowi, low_col);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 4'b1111;
         cs      <= 4'b1111;
         div     <= '0;
         st      <= ST_SCAN;
         rowi    <= 2'd0;
         row_n_q <= 4'b1110;
         cand    <= 2'd0;
         deb_cnt <= '0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         sync1   <= kp.col_n;
         cs      <= sync1;
         div     <= div + 1'b1;
         st      <= st_nxt;
         rowi    <= rowi_nxt;
         row_n_q <= ~(4'b0001 << rowi_nxt);
         cand    <= cand_nxt;
         deb_cnt <= cnt_nxt;
         code_q  <= code_nxt;
         valid_q <= valid_nxt;
         data_q  <= data_nxt;
      end
   end

   always_comb begin
      st_nxt    = st;
      rowi_nxt  = rowi;
      cand_nxt  = cand;
      cnt_nxt   = deb_cnt;
      code_nxt  = code_q;
      valid_nxt = 1'b0;
      data_nxt  = data_q;
      accept    = 1'b0;

      if (tick) begin
         case (st)
            ST_SCAN: begin
               if (any_low) begin
                  cand_nxt = low_col;
                  cnt_nxt  = CNT_W'(1);
                  if (DEBOUNCE_TICKS == 1) accept = 1'b1;
                  else                     st_nxt = ST_DEBOUNCE;
               end else begin
                  rowi_nxt = rowi + 2'd1;
               end
            end
            ST_DEBOUNCE: begin
               if (any_low && (low_col == cand)) begin
                  if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) accept  = 1'b1;
                  else                                   cnt_nxt = cnt_inc;
               end else begin
                  st_nxt   = ST_SCAN;
                  rowi_nxt = rowi + 2'd1;
                  cnt_nxt  = '0;
               end
            end
            ST_RELEASE: begin
               if (!any_low) begin
                  if (cnt_inc == CNT_W'(DEBOUNCE_TICKS)) begin
                     st_nxt   = ST_SCAN;
                     rowi_nxt = rowi + 2'd1;
                     cnt_nxt  = '0;
                  end else begin
                     cnt_nxt = cnt_inc;
                  end
               end else begin
                  cnt_nxt = '0;
               end
            end
            default: begin
               st_nxt  = ST_SCAN;
               cnt_nxt = '0;
            end
         endcase
      end

      if (accept) begin
         code_nxt  = digit;
         valid_nxt = 1'b1;
         data_nxt  = {data_q[27:0], digit};
         st_nxt    = ST_RELEASE;
         cnt_nxt   = '0;
      end

      // Clear wins over a same-cycle shift; key_code/key_valid are unaffected.
      if (kp.clear) data_nxt = 32'h0;
   end

   assign kp.row_n     = row_n_q;
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.data      = data_q;
   assign kp.state     = st;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scanned 4x4 hex matrix keypad input block: the input-side counterpart of the board's multiplexed seven-segment output scanner.
- Drives one keypad row low at a time and samples the four column lines.
- Debounces presses and releases, then shifts each accepted hex digit into a 32-bit entry register.
- The entry register feeds the seven-segment display data bus and the CPU's user-input path.

Parameters:
SCAN_DIV_W, 15, width of free-running scan divider; scan_tick fires when divider is all ones (period 2^SCAN_DIV_W clk)
DEBOUNCE_TICKS, 4, consecutive scan_ticks with a stable reading required to accept a press or a release (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
col_n  input  4  keypad column lines, active-low (pulled up), asynchronous to clk
clear  input  1  synchronous clear of data register
row_n  output  4  row drive, exactly one bit low at all times
key_code  output  4  last accepted hex digit
key_valid  output  1  one-clk pulse when a key is accepted
data  output  32  entry register; newest digit in data[3:0]
state  output  2  debug: 0=SCAN, 1=DEBOUNCE, 2=RELEASE

Behaviour:
- Reset values (async, rst_n low): row_n=4'b1110, key_code=0, key_valid=0, data=0, state=SCAN, divider=0, debounce counter=0, synchronizer flops=4'b1111.
- col_n passes through a 2-flop synchronizer; all decisions use the synchronized value cs.
- Divider increments every clk and wraps; scan_tick=&divider. Decisions are taken only on scan_tick; a row change settles for one full tick period before it is sampled.
- Key map (row r drives row_n[r] low; column c is col_n[c]):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN, on tick:
  - Any cs bit low: latch current row and lowest-index low column as candidate; deb_cnt=1.
    - If DEBOUNCE_TICKS==1, accept immediately.
    - Otherwise go to DEBOUNCE. Row is held.
  - All cs bits high: rotate row_n left (1110->1101->1011->0111->1110).
- DEBOUNCE, on tick:
  - Candidate column still low and no lower-index column low: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, accept.
  - Otherwise: return to SCAN, rotate row, deb_cnt=0. No output.
- Accept (same clk as the deciding tick):
  - key_code <= mapped digit.
  - key_valid=1 for exactly that one clk.
  - data <= {data[27:0], digit}.
  - Go to RELEASE with deb_cnt=0. Row is held.
- RELEASE, on tick:
  - cs==4'b1111: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, go to SCAN, rotate row, deb_cnt=0.
  - Any cs bit low: deb_cnt=0.
  - No repeat: a held key produces exactly one key_valid.
- Multiple keys in the scanned row: the lowest column index wins. Keys in other rows are ignored until RELEASE completes.
- clear:
  - data <= 0 on that clk, overriding a same-clk shift.
  - key_code and key_valid still update normally.
  - State machine is unaffected.
- data shifting discards the oldest digit (data[31:28]) after 8 entries.
- rst_n asserted mid-press: immediate return to reset values. After release of reset, a still-held key is re-detected from SCAN as a new press.
- state and all outputs are registered; no combinational path from col_n to any output.

Test Plan:
All scenarios use SCAN_DIV_W=4 (tick every 16 clk) and DEBOUNCE_TICKS=3.
1. Reset with no keys -> row_n cycles 1110,1101,1011,0111,1110 at one step per tick; key_valid never asserts; data=0.
2. Hold row1/col2 ("6") stable for 10 ticks, then release -> exactly one key_valid pulse on the 3rd confirming tick; key_code=6; data=32'h0000_0006; row_n held at 1101 until 3 high ticks after release.
3. Bounce on "0" (r3,c1): low 1 tick, high 1 tick, then low 5 ticks -> first attempt aborted to SCAN; after the row returns, a single accept; data shifts in 0.
4. Enter 1,2,3,A,4,5,6,B,7 -> data=32'h23A4_56B7 (oldest digit dropped); 9 key_valid pulses total.
5. Press r0 col1 and col3 together ("2","A") -> key_code=2 only; after both are released, one entry appended.
6. Assert clear on the accept clk of "F", then assert rst_n low during the RELEASE of a later key:
   - After clear: data=0, key_code=F, key_valid pulse seen.
   - After reset: all outputs at reset values immediately; the held key is re-accepted after reset deassertion.
